serial_adder_nand: RTL and testbench
====================================

# serial_adder_nand

Parametrised multi-cycle adder that processes a WIDTH-bit addition in slices of BITS_PER_CYCLE bits per clock, LSB slice first. Each slice is a ripple chain of structural NAND-only full-adder cells, with the carry held in a flop between slices. It is the sequential, width-generalised successor of the team's NAND-only 1-bit adder cells. It sits in the primitive-logic library as an area-lean arithmetic unit for datapaths that can tolerate multi-cycle latency.

## Interface
Parameters:
- WIDTH, 8, operand and result width; must be ≥ 1.
- BITS_PER_CYCLE, 1, slice width; must divide WIDTH, otherwise elaboration error.
- Derived K = WIDTH / BITS_PER_CYCLE, the number of slice cycles.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; accepted only when busy = 0.
- a, input, WIDTH, operand A; sampled on the accepting edge.
- b, input, WIDTH, operand B; sampled on the accepting edge.
- cin, input, 1, carry-in; sampled on the accepting edge.
- sub, input, 1, subtract request; sampled on the accepting edge; ignored unless SERIAL_ADDER_SUB_EN is defined.
- busy, output, 1, high while an operation is in RUN.
- done, output, 1, one-cycle pulse when the result is valid.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of the MSB.
- ovf, output, 1, two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - Load A and B shift registers and a slice counter = 0.
  - Carry flop ← cin, or ← 1 in subtract mode.
- RUN, each edge:
  - Add the low BITS_PER_CYCLE bits of A and B (B inverted in subtract mode) plus the carry flop.
  - Shift the slice result into the sum register from the MSB side.
  - Update the carry flop; increment the counter.
  - On the K-th slice, transition to DONE.
- DONE:
  - done=1; sum, cout and ovf are valid.
  - ovf = carry into the MSB XOR carry out of the MSB.
  - start=1 → RUN, a back-to-back accept on the same edge.
  - Otherwise → IDLE.
- sum, cout and ovf hold their last value until the next result is written. They are never cleared by returning to IDLE.
- start while busy=1 is ignored. Operands and the in-flight result are unaffected.
- Subtract mode: result = a − b; cin is ignored; cout=1 means no borrow.
- Arithmetic is modulo 2^WIDTH. There is no saturation.

## Timing
- Reset values: state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal registers 0.
- Reset asserted mid-RUN or mid-DONE:
  - The operation is abandoned immediately.
  - No done pulse is produced after release.
- Accepting edge E0. Slices are computed on edges E1..EK. done is high for the cycle following EK.
- Latency from the accepting edge to done is K+1 edges.
- Throughput is one result per K+1 cycles with start held high.
- busy is high from E0 through EK. It is low in the DONE cycle.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - sub is honoured.
  - The B slice is inverted through NAND-built inverters.
  - The initial carry is forced to 1.
- SERIAL_ADDER_SUB_EN undefined:
  - sub is ignored; the block always computes a + b + cin.
  - The inversion logic is not instantiated.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - a counter-width function clog2(K+1).
- Natural sub-module: fa_nand_cell, a 1-bit full adder built only from nand primitives, purely structural.
  - Instantiated BITS_PER_CYCLE times per slice in a generate loop.
  - The MSB cell's carry-in is exported for the ovf computation.

## Test plan
- WIDTH=8, B=1:
  - Stimulus: a=0xFF, b=0x01, cin=0.
  - Response: sum=0x00, cout=1, ovf=0; done exactly 9 edges after the accepting edge.
- WIDTH=8, B=1:
  - Stimulus: a=0x7F, b=0x01.
  - Response: sum=0x80, cout=0, ovf=1.
- SUB_EN defined:
  - Stimulus: a=0x05, b=0x07, sub=1.
  - Response: sum=0xFE, cout=0, ovf=0.
- WIDTH=8, B=4:
  - Stimulus: a=0x3C, b=0x55, cin=1.
  - Response: sum=0x92; done 3 edges after accept.
  - Back-to-back start held high: a new accept on the same edge as DONE.
- Start pulses during RUN:
  - Stimulus: start pulsed with different operands while busy=1.
  - Response: ignored; the original result is delivered.
- Reset mid-operation:
  - Stimulus: rst_n low for one cycle during RUN.
  - Response: all outputs 0 asynchronously; no done follows.

Source files
------------

// File: rtl/serial_adder_nand_pkg.sv
// rtl/serial_adder_nand_pkg.sv - shared state encoding and sizing helper for the NAND serial adder
package serial_adder_nand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bits needed to represent values 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_adder_nand_fa_cell.sv
// rtl/serial_adder_nand_fa_cell.sv - 1-bit full adder built from nine two-input nand primitives
module fa_nand_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    wire n_ab;
    wire n_a;
    wire n_b;
    wire x_ab;
    wire n_xc;
    wire n_x;
    wire n_c;
    wire s_w;
    wire co_w;

    nand g_ab (n_ab, a, b);
    nand g_a  (n_a, a, n_ab);
    nand g_b  (n_b, b, n_ab);
    nand g_x  (x_ab, n_a, n_b);
    nand g_xc (n_xc, x_ab, ci);
    nand g_nx (n_x, x_ab, n_xc);
    nand g_nc (n_c, ci, n_xc);
    nand g_s  (s_w, n_x, n_c);
    nand g_co (co_w, n_xc, n_ab);

    assign s  = s_w;
    assign co = co_w;

endmodule

// File: rtl/serial_adder_nand.sv
// rtl/serial_adder_nand.sv - multi-cycle WIDTH-bit adder, BITS_PER_CYCLE bits per clock, LSB slice first
// Optional subtract path enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_nand
    import serial_adder_nand_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int BPC   = BITS_PER_CYCLE;
    localparam int K     = WIDTH / BPC;
    localparam int CNT_W = clog2(K + 1);

    generate
        if (WIDTH < 1 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_check
            $error("serial_adder_nand: BITS_PER_CYCLE must divide WIDTH and WIDTH must be at least 1");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               init_carry;
    logic [WIDTH-1:0]   acc_next;

    wire  [BPC-1:0]     b_slice;
    wire  [BPC-1:0]     s_slice;
    wire  [BPC:0]       c;

`ifdef SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;

    // Conditional inverter: b ^ sub_q, four nands per bit.
    generate
        for (genvar i = 0; i < BPC; i++) begin : g_binv
            wire n0;
            wire n1;
            wire n2;
            nand g_n0 (n0, b_q[i], sub_q);
            nand g_n1 (n1, b_q[i], n0);
            nand g_n2 (n2, sub_q, n0);
            nand g_n3 (b_slice[i], n1, n2);
        end
    endgenerate

    assign init_carry = sub ? 1'b1 : cin;
`else
    logic sub_unused;

    assign sub_unused = sub;
    assign b_slice    = b_q[BPC-1:0];
    assign init_carry = cin;
`endif

    assign c[0] = carry_q;

    generate
        for (genvar i = 0; i < BPC; i++) begin : g_slice
            fa_nand_cell u_fa (
                .a  (a_q[i]),
                .b  (b_slice[i]),
                .ci (c[i]),
                .s  (s_slice[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    // New slice enters from the MSB side; after K slices the LSB slice sits at bit 0.
    assign acc_next = WIDTH'({s_slice, acc_q} >> BPC);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    carry_d = init_carry;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> BPC;
                b_d     = b_q >> BPC;
                acc_d   = acc_next;
                carry_d = c[BPC];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    state_d = ST_DONE;
                    sum_d   = acc_next;
                    cout_d  = c[BPC];
                    ovf_d   = c[BPC] ^ c[BPC-1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_nand.sv
// tb/tb_serial_adder_nand.sv - directed bench for serial_adder_nand at 1 and 4 bits per cycle
module tb_serial_adder_nand;

    logic       clk;
    logic       rst_n;

    logic       start1, cin1, sub1;
    logic [7:0] a1, b1;
    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;

    logic       start4, cin4, sub4;
    logic [7:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [7:0] sum4;

    int checks = 0;
    int errors = 0;
    int edges;
    int seen;

    serial_adder_nand #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder_nand #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Leaves the caller at the falling edge after the accepting edge E0.
    task automatic issue1(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
        @(negedge clk);
        a1 = av; b1 = bv; cin1 = cv; sub1 = sv; start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
    endtask

    // Edge count includes E0; bounded so a missing done cannot hang the run.
    task automatic wait_done1(input int first, output int n);
        n = first;
        while (done1 !== 1'b1 && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1",  sum1,  0);
        check("rst_cout1", cout1, 0);
        check("rst_ovf1",  ovf1,  0);
        check("rst_sum4",  sum4,  0);
        check("rst_busy4", busy4, 0);
        rst_n = 1'b1;

        // 0xFF + 0x01: wraps to zero with carry out, no signed overflow.
        issue1(8'hFF, 8'h01, 1'b0, 1'b0);
        check("ff01_busy_run", busy1, 1);
        wait_done1(1, edges);
        check("ff01_latency", edges, 9);
        check("ff01_busy_done", busy1, 0);
        check("ff01_sum",  sum1,  8'h00);
        check("ff01_cout", cout1, 1);
        check("ff01_ovf",  ovf1,  0);
        @(negedge clk);
        check("ff01_done_pulse", done1, 0);
        check("ff01_idle_busy", busy1, 0);
        check("ff01_sum_hold", sum1, 8'h00);
        check("ff01_cout_hold", cout1, 1);

        // 0x7F + 0x01: positive overflow.
        issue1(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done1(1, edges);
        check("7f01_latency", edges, 9);
        check("7f01_sum",  sum1,  8'h80);
        check("7f01_cout", cout1, 0);
        check("7f01_ovf",  ovf1,  1);

        // 0x05 - 0x07 when subtract is built in; otherwise sub is ignored and it adds.
        issue1(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done1(1, edges);
`ifdef SERIAL_ADDER_SUB_EN
        check("sub_sum",  sum1,  8'hFE);
        check("sub_cout", cout1, 0);
        check("sub_ovf",  ovf1,  0);
`else
        check("nosub_sum",  sum1,  8'h0C);
        check("nosub_cout", cout1, 0);
        check("nosub_ovf",  ovf1,  0);
`endif

        // 0x80 + 0x80 + 1: negative overflow, carry out set.
        issue1(8'h80, 8'h80, 1'b1, 1'b0);
        wait_done1(1, edges);
        check("8080_sum",  sum1,  8'h01);
        check("8080_cout", cout1, 1);
        check("8080_ovf",  ovf1,  1);

        // Start pulses with other operands while busy must be ignored.
        issue1(8'h12, 8'h34, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            a1 = 8'hFF; b1 = 8'hFF; cin1 = 1'b1; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
        end
        wait_done1(4, edges);
        check("ign_latency", edges, 9);
        check("ign_sum",  sum1,  8'h46);
        check("ign_cout", cout1, 0);
        check("ign_ovf",  ovf1,  0);

        // Reset mid-RUN: outputs clear at once and the operation never completes.
        issue1(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_busy", busy1, 0);
        check("mrst_done", done1, 0);
        check("mrst_sum",  sum1,  0);
        check("mrst_cout", cout1, 0);
        check("mrst_ovf",  ovf1,  0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done1 === 1'b1 || busy1 === 1'b1) seen++;
        end
        check("mrst_no_done", seen, 0);
        check("mrst_sum_after", sum1, 0);

        // Four bits per cycle, start held high for a back-to-back accept.
        @(negedge clk);
        a4 = 8'h3C; b4 = 8'h55; cin4 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b4_busy_e0", busy4, 1);
        a4 = 8'hF0; b4 = 8'h20; cin4 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b4_busy_e1", busy4, 1);
        check("b4_done_e1", done4, 0);
        @(posedge clk);
        @(negedge clk);
        check("b4_done_e2", done4, 1);
        check("b4_busy_e2", busy4, 0);
        check("b4_sum",  sum4,  8'h92);
        check("b4_cout", cout4, 0);
        check("b4_ovf",  ovf4,  1);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        check("b2b_busy", busy4, 1);
        check("b2b_done_low", done4, 0);
        check("b2b_sum_hold", sum4, 8'h92);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done_e1", done4, 0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_done", done4, 1);
        check("b2b_sum",  sum4,  8'h10);
        check("b2b_cout", cout4, 1);
        check("b2b_ovf",  ovf4,  0);
        @(negedge clk);
        check("b2b_idle_done", done4, 0);
        check("b2b_idle_busy", busy4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
